rhd_spi_slave: RTL and testbench
================================

# rhd_spi_slave

Synthesizable SPI responder that models the RHD2164 side of the link: it receives 16-bit MSB-first command words on MOSI and returns two 16-bit words (channel A and channel B) on a single DDR MISO line. It sits in loopback and self-test builds in place of the headstage, opposite spi_master, and runs on the fabric clock with SCLK/CS oversampled. Upstream logic supplies the A/B response words per frame and consumes the received command word.

## Interface
- SYNC_STAGES, 2, synchronizer depth for i_cs_n, i_sclk, i_mosi (≥2)
- i_clk  in  1  fabric clock
- i_rst  in  1  asynchronous, active-low reset
- i_cs_n  in  1  chip select, active low, asynchronous to i_clk
- i_sclk  in  1  SPI clock, idles low (CPOL=0), asynchronous
- i_mosi  in  1  command data, MSB first
- o_miso  out  1  DDR response data; 0 when idle
- i_tx_a  in  16  channel A response word, captured at frame start
- i_tx_b  in  16  channel B response word, captured at frame start
- o_rx  out  16  last good received command word
- o_rx_valid  out  1  one-cycle pulse: o_rx updated
- o_frame_err  out  1  one-cycle pulse: frame ended malformed
- o_busy  out  1  high while a frame is in progress

## Operation
- All three SPI inputs pass through SYNC_STAGES flops; sync flops reset to cs_n=1, sclk=0, mosi=0. Edges are detected on the last sync stage against one extra delayed copy.
- States: IDLE, WAIT_CS_HIGH, SHIFT.
- Reset → WAIT_CS_HIGH. WAIT_CS_HIGH → IDLE when synced cs_n=1 (a frame already in progress when reset releases is never joined).
- IDLE, CS fall: latch i_tx_a → sh_a, i_tx_b → sh_b; clear rise/fall counters (5 bits each) and error flag; o_miso ← A[15]; o_busy ← 1; → SHIFT. If synced sclk=1 at CS fall, set error flag.
- SHIFT, SCLK rise k (k=1..16): shift synced mosi into rx shift register LSB; o_miso ← A[16-k]; rise_cnt++.
- SHIFT, SCLK fall k (k=1..16): o_miso ← B[16-k]; fall_cnt++. After fall 16, MISO holds B[0].
- Edges beyond 16 (either polarity): no shift, no MISO change, set error flag; counters saturate at 31.
- SHIFT, CS rise: o_busy ← 0, o_miso ← 0, → IDLE. If rise_cnt=16, fall_cnt=16, and no error: o_rx ← rx shift register, pulse o_rx_valid. Otherwise pulse o_frame_err; o_rx unchanged.
- CS rise and an SCLK edge detected in the same cycle: CS rise wins; the edge is ignored and not counted.
- Reset values: o_miso=0, o_rx=0, o_rx_valid=0, o_frame_err=0, o_busy=0; internal shift registers and counters 0.
- Asynchronous reset mid-frame aborts the frame with no pulse on o_rx_valid or o_frame_err.

## Timing
- Input-to-action latency: SYNC_STAGES+1 i_clk cycles from a pin edge to the registered o_miso/o_rx update (3 cycles at default).
- The bit seen by the master at falling edge k is A[16-k]. The bit seen at rising edge k (k=2..16) is B[17-k]. This matches the spi_master DDR sampling, so B[0] is never captured in-frame.
- Correct data requires the SCLK half-period to be ≥ SYNC_STAGES+2 i_clk cycles. With a shared clock, spi_master i_clk_div ≥ 4 at default.
- o_rx_valid and o_frame_err fire SYNC_STAGES+1 cycles after the CS pin rises and are mutually exclusive.
- i_tx_a/i_tx_b are sampled only on the CS-fall cycle; they may change freely at any other time.
- Minimum CS-high time between frames: SYNC_STAGES+2 cycles.

## Test plan
- Basic loopback: spi_master with i_clk_div=4 on the same clock. CS framed around i_start..o_done, i_din=16'hA5C3, i_tx_a=16'h1234, i_tx_b=16'hBEEF → o_rx=16'hA5C3 with one o_rx_valid pulse; master o_dout_a=16'h1234; o_dout_b[15:1]=BEEF[15:1].
- Back-to-back frames: 16'h0001 then 16'hFFFE with tx_a 16'h8000/16'h0001 → two valid pulses, o_rx and dout_a match each frame, o_frame_err never asserts.
- Short frame: CS raised after 10 SCLK periods → o_frame_err pulses once, o_rx keeps its previous value, o_busy=0, o_miso=0.
- Long frame: 17 SCLK periods → o_frame_err pulses once; MISO stays at B[0] through the extra edges.
- Reset mid-frame: assert i_rst after 5 bits with CS still low, release it, finish the frame → no pulses. The next full frame 16'h5A5A yields o_rx_valid with o_rx=16'h5A5A.
- Tx capture: change i_tx_a from 16'hAAAA to 16'h5555 one cycle after CS fall → master dout_a=16'hAAAA.

Source files
------------

// File: rtl/rhd_spi_slave.sv
// SPI responder standing in for the RHD2164: receives 16-bit MSB-first commands on MOSI
// and returns channel A on SCLK rising edges and channel B on falling edges of one MISO line.
module rhd_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cs_n,
    input  logic        i_sclk,
    input  logic        i_mosi,
    output logic        o_miso,
    input  logic [15:0] i_tx_a,
    input  logic [15:0] i_tx_b,
    output logic [15:0] o_rx,
    output logic        o_rx_valid,
    output logic        o_frame_err,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CS_HIGH,
        SHIFT
    } state_t;

    localparam logic [7:0] FLUSH_LAST = 8'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_d;
    logic                   sclk_d;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sclk_rise;
    logic                   sclk_fall;

    state_t      state;
    logic [7:0]  flush_cnt;
    logic [15:0] sh_a;
    logic [15:0] sh_b;
    logic [15:0] rx_sh;
    logic [4:0]  rise_cnt;
    logic [4:0]  fall_cnt;
    logic        err;

    // NOTE: every register here, including the data shift registers, gets a reset value;
    // sequential state is only ever written with non-blocking assignments.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            cs_d      <= cs_sync[SYNC_STAGES-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= WAIT_CS_HIGH;
            flush_cnt   <= '0;
            sh_a        <= '0;
            sh_b        <= '0;
            rx_sh       <= '0;
            rise_cnt    <= '0;
            fall_cnt    <= '0;
            err         <= 1'b0;
            o_miso      <= 1'b0;
            o_rx        <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                // The sync chain resets to "deselected"; only trust cs_n once it holds real samples,
                // so a frame already running at reset release is never joined.
                WAIT_CS_HIGH: begin
                    if (flush_cnt != FLUSH_LAST)
                        flush_cnt <= flush_cnt + 8'd1;
                    else if (cs_s)
                        state <= IDLE;
                end
                IDLE: begin
                    if (cs_fall) begin
                        sh_a     <= i_tx_a;
                        sh_b     <= i_tx_b;
                        rise_cnt <= '0;
                        fall_cnt <= '0;
                        err      <= sclk_s;
                        o_miso   <= i_tx_a[15];
                        o_busy   <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        o_busy <= 1'b0;
                        o_miso <= 1'b0;
                        state  <= IDLE;
                        if (rise_cnt == 5'd16 && fall_cnt == 5'd16 && !err) begin
                            o_rx       <= rx_sh;
                            o_rx_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        // Bit index 15-cnt is the bitwise complement of the low four count bits.
                        if (!rise_cnt[4]) begin
                            rx_sh  <= {rx_sh[14:0], mosi_s};
                            o_miso <= sh_a[~rise_cnt[3:0]];
                        end else begin
                            err <= 1'b1;
                        end
                        if (rise_cnt != 5'd31)
                            rise_cnt <= rise_cnt + 5'd1;
                    end else if (sclk_fall) begin
                        if (!fall_cnt[4])
                            o_miso <= sh_b[~fall_cnt[3:0]];
                        else
                            err <= 1'b1;
                        if (fall_cnt != 5'd31)
                            fall_cnt <= fall_cnt + 5'd1;
                    end
                end
                default: state <= WAIT_CS_HIGH;
            endcase
        end
    end

endmodule

// File: tb/tb_rhd_spi_slave.sv
// Directed bench for rhd_spi_slave: a bench-side DDR SPI master drives frames and
// collects MISO the way spi_master samples it (A on SCLK falls, B on SCLK rises 2..16).
module tb_rhd_spi_slave;

    localparam int H = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_cs_n = 1'b1;
    logic        i_sclk = 1'b0;
    logic        i_mosi = 1'b0;
    logic [15:0] i_tx_a = '0;
    logic [15:0] i_tx_b = '0;
    logic        o_miso;
    logic [15:0] o_rx;
    logic        o_rx_valid;
    logic        o_frame_err;
    logic        o_busy;

    rhd_spi_slave #(.SYNC_STAGES(2)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cs_n     (i_cs_n),
        .i_sclk     (i_sclk),
        .i_mosi     (i_mosi),
        .o_miso     (o_miso),
        .i_tx_a     (i_tx_a),
        .i_tx_b     (i_tx_b),
        .o_rx       (o_rx),
        .o_rx_valid (o_rx_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_err = 0;
    int v0, e0;

    always @(posedge i_clk) begin
        if (o_rx_valid) n_valid <= n_valid + 1;
        if (o_frame_err) n_err <= n_err + 1;
    end

    logic        rise_smp [1:20];
    logic        fall_smp [1:20];
    logic        m2, m3, busy_mid;
    logic [15:0] dout_a, dout_b;

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, input int k);
        i_mosi = b;
        cyc(H);
        rise_smp[k] = o_miso;
        i_sclk = 1'b1;
        cyc(H);
        fall_smp[k] = o_miso;
        i_sclk = 1'b0;
    endtask

    task automatic frame_start();
        v0 = n_valid;
        e0 = n_err;
        i_cs_n = 1'b0;
        cyc(2);
        m2 = o_miso;
        cyc(1);
        m3 = o_miso;
        busy_mid = o_busy;
    endtask

    task automatic frame_end();
        cyc(H);
        i_cs_n = 1'b1;
        i_mosi = 1'b0;
        cyc(8);
    endtask

    task automatic frame_body(input logic [15:0] din, input int nbits, input int first);
        for (int k = first; k <= nbits; k++)
            spi_bit((k <= 16) ? din[16-k] : 1'b0, k);
        frame_end();
        dout_a = '0;
        dout_b = '0;
        for (int k = 1; k <= 16; k++) dout_a[16-k] = fall_smp[k];
        for (int k = 2; k <= 16; k++) dout_b[17-k] = rise_smp[k];
    endtask

    task automatic frame(input logic [15:0] din, input int nbits);
        frame_start();
        frame_body(din, nbits, 1);
    endtask

    initial begin
        cyc(3);
        chk("reset_miso", 32'(o_miso), 32'h0);
        chk("reset_rx", 32'(o_rx), 32'h0);
        chk("reset_valid", 32'(o_rx_valid), 32'h0);
        chk("reset_err", 32'(o_frame_err), 32'h0);
        chk("reset_busy", 32'(o_busy), 32'h0);
        i_rst = 1'b1;
        cyc(10);

        // Basic loopback
        i_tx_a = 16'h1234;
        i_tx_b = 16'hBEEF;
        frame(16'hA5C3, 16);
        chk("f1_rx", 32'(o_rx), 32'hA5C3);
        chk("f1_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("f1_err_cnt", 32'(n_err - e0), 32'd0);
        chk("f1_dout_a", 32'(dout_a), 32'h1234);
        chk("f1_dout_b", 32'(dout_b[15:1]), 32'(15'h5F77));
        chk("f1_busy_mid", 32'(busy_mid), 32'h1);
        chk("f1_busy_end", 32'(o_busy), 32'h0);

        // Back-to-back frames; first also checks CS-fall to MISO latency
        i_tx_a = 16'h8000;
        i_tx_b = 16'h0F0F;
        frame(16'h0001, 16);
        chk("f2_miso_lat2", 32'(m2), 32'h0);
        chk("f2_miso_lat3", 32'(m3), 32'h1);
        chk("f2_rx", 32'(o_rx), 32'h0001);
        chk("f2_dout_a", 32'(dout_a), 32'h8000);
        chk("f2_dout_b", 32'(dout_b[15:1]), 32'(15'h0787));
        chk("f2_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("f2_err_cnt", 32'(n_err - e0), 32'd0);
        i_tx_a = 16'h0001;
        frame(16'hFFFE, 16);
        chk("f3_rx", 32'(o_rx), 32'hFFFE);
        chk("f3_dout_a", 32'(dout_a), 32'h0001);
        chk("f3_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("f3_err_cnt", 32'(n_err - e0), 32'd0);

        // Short frame
        frame(16'h1357, 10);
        chk("short_err_cnt", 32'(n_err - e0), 32'd1);
        chk("short_valid_cnt", 32'(n_valid - v0), 32'd0);
        chk("short_rx_kept", 32'(o_rx), 32'hFFFE);
        chk("short_busy", 32'(o_busy), 32'h0);
        chk("short_miso", 32'(o_miso), 32'h0);

        // Long frame: MISO holds B[0] through the 17th edges
        i_tx_a = 16'h1234;
        i_tx_b = 16'h0001;
        frame(16'h2468, 17);
        chk("long_err_cnt", 32'(n_err - e0), 32'd1);
        chk("long_valid_cnt", 32'(n_valid - v0), 32'd0);
        chk("long_miso_rise17", 32'(rise_smp[17]), 32'h1);
        chk("long_miso_fall17", 32'(fall_smp[17]), 32'h1);
        chk("long_rx_kept", 32'(o_rx), 32'hFFFE);

        // Reset mid-frame, then finish the frame with CS still low
        frame_start();
        for (int k = 1; k <= 5; k++) spi_bit(1'b1, k);
        i_rst = 1'b0;
        cyc(2);
        i_rst = 1'b1;
        frame_body(16'hFFFF, 16, 6);
        chk("rstmid_valid_cnt", 32'(n_valid - v0), 32'd0);
        chk("rstmid_err_cnt", 32'(n_err - e0), 32'd0);
        chk("rstmid_rx", 32'(o_rx), 32'h0);
        chk("rstmid_busy", 32'(o_busy), 32'h0);
        frame(16'h5A5A, 16);
        chk("after_rst_rx", 32'(o_rx), 32'h5A5A);
        chk("after_rst_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("after_rst_err_cnt", 32'(n_err - e0), 32'd0);

        // Tx capture: change i_tx_a right after the capture cycle
        i_tx_a = 16'hAAAA;
        frame_start();
        i_tx_a = 16'h5555;
        frame_body(16'h0F0F, 16, 1);
        chk("txcap_dout_a", 32'(dout_a), 32'hAAAA);
        chk("txcap_rx", 32'(o_rx), 32'h0F0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
